// File: rtl/ysyx_22050710_div_ctrl.sv
// Radix-2 restoring divide sequencer for RV64M div/rem (incl. W forms); result N+1 edges after accept, specials 1 edge.
// Accepts only in IDLE; holds the result in DONE until i_out_ready, and i_flush aborts from any busy state.
module ysyx_22050710_div_ctrl #(
  parameter int WORD_WD = 64,
  parameter int CNT_WD  = 7
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WORD_WD-1:0] i_src_a,
  input  logic [WORD_WD-1:0] i_src_b,
  input  logic [1:0]         i_div_op,
  input  logic               i_word_sel,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WORD_WD-1:0] o_result
);

  localparam int HALF_WD = WORD_WD / 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic       word;
    logic       sign_a;
    logic       sign_b;
  } meta_t;

  state_t state_q, state_d;
  meta_t  meta_q;

  logic [WORD_WD-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic [CNT_WD-1:0]  cnt_q;

  // ---- accept-side operand conditioning ----
  logic               in_signed, accept, div0, ovf, special;
  logic               a_neg, b_neg;
  logic [WORD_WD-1:0] a_ext, b_ext, mag_a, mag_b, sp_raw, sp_res;

  assign in_signed = ~i_div_op[0];
  assign accept    = (state_q == S_IDLE) & i_in_valid & ~i_flush;

  always_comb begin
    a_ext = i_src_a;
    b_ext = i_src_b;
    if (i_word_sel) begin
      a_ext = {{HALF_WD{in_signed & i_src_a[HALF_WD-1]}}, i_src_a[HALF_WD-1:0]};
      b_ext = {{HALF_WD{in_signed & i_src_b[HALF_WD-1]}}, i_src_b[HALF_WD-1:0]};
    end
  end

  assign a_neg = in_signed & a_ext[WORD_WD-1];
  assign b_neg = in_signed & b_ext[WORD_WD-1];
  assign mag_a = a_neg ? -a_ext : a_ext;
  assign mag_b = b_neg ? -b_ext : b_ext;

  assign div0 = (b_ext == '0);
  assign ovf  = in_signed & (i_word_sel
              ? ((i_src_a[HALF_WD-1:0] == {1'b1, {(HALF_WD-1){1'b0}}}) & (i_src_b[HALF_WD-1:0] == '1))
              : ((i_src_a == {1'b1, {(WORD_WD-1){1'b0}}}) & (i_src_b == '1)));
  assign special = div0 | ovf;

  // div0: q = all ones, r = dividend; overflow: q = dividend, r = 0
  assign sp_raw = i_div_op[1] ? (div0 ? a_ext : '0) : (div0 ? '1 : a_ext);
  assign sp_res = i_word_sel ? {{HALF_WD{sp_raw[HALF_WD-1]}}, sp_raw[HALF_WD-1:0]} : sp_raw;

  // ---- one restoring iteration ----
  logic [WORD_WD:0]   part_rem, diff;
  logic               q_bit, meta_signed;
  logic [WORD_WD-1:0] rem_nxt, quo_nxt, q_fix, r_fix, sel_res, fin_res;

  assign part_rem = {rem_q, dvd_q[WORD_WD-1]};
  assign diff     = part_rem - {1'b0, dvs_q};
  assign q_bit    = ~diff[WORD_WD];
  assign rem_nxt  = q_bit ? diff[WORD_WD-1:0] : part_rem[WORD_WD-1:0];
  assign quo_nxt  = {quo_q[WORD_WD-2:0], q_bit};

  assign meta_signed = ~meta_q.op[0];
  assign q_fix   = (meta_signed & (meta_q.sign_a ^ meta_q.sign_b)) ? -quo_nxt : quo_nxt;
  assign r_fix   = (meta_signed & meta_q.sign_a) ? -rem_nxt : rem_nxt;
  assign sel_res = meta_q.op[1] ? r_fix : q_fix;
  assign fin_res = meta_q.word ? {{HALF_WD{sel_res[HALF_WD-1]}}, sel_res[HALF_WD-1:0]} : sel_res;

  // ---- control FSM ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: begin
        if (i_flush)                          state_d = S_IDLE;
        else if (cnt_q == CNT_WD'(1))         state_d = S_DONE;
      end
      S_DONE: if (i_flush | i_out_ready)      state_d = S_IDLE;
      default:                                state_d = S_IDLE;
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q   <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      o_result <= '0;
    end else if (accept) begin
      meta_q   <= '{op: i_div_op, word: i_word_sel, sign_a: a_neg, sign_b: b_neg};
      // W ops left-align the 32-bit magnitude so the shift starts at bit 31
      dvd_q    <= i_word_sel ? {mag_a[HALF_WD-1:0], {HALF_WD{1'b0}}} : mag_a;
      dvs_q    <= mag_b;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= special ? '0 : (i_word_sel ? CNT_WD'(HALF_WD) : CNT_WD'(WORD_WD));
      if (special) o_result <= sp_res;
    end else if ((state_q == S_CALC) && !i_flush) begin
      dvd_q <= {dvd_q[WORD_WD-2:0], 1'b0};
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNT_WD'(1)) o_result <= fin_res;
    end
  end

  assign o_in_ready  = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_out_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_ysyx_22050710_div_ctrl.sv
// Directed + randomized bench for the divide sequencer against an arithmetic reference model.
module tb_ysyx_22050710_div_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_src_a;
  logic [63:0] i_src_b;
  logic [1:0]  i_div_op;
  logic        i_word_sel;
  logic        i_flush;
  logic        o_busy;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_result;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  ysyx_22050710_div_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_src_a     (i_src_a),
    .i_src_b     (i_src_b),
    .i_div_op    (i_div_op),
    .i_word_sel  (i_word_sel),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics written with plain signed/unsigned arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    logic [63:0] r;
    int          sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    r = '0;
    r32 = '0;
    if (w) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      case (op)
        OP_DIV:  if (sb32 == 0) r32 = 32'hFFFF_FFFF;
                 else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = sa32;
                 else r32 = sa32 / sb32;
        OP_DIVU: if (ub32 == 0) r32 = 32'hFFFF_FFFF; else r32 = ua32 / ub32;
        OP_REM:  if (sb32 == 0) r32 = sa32;
                 else if (sa32 == 32'sh8000_0000 && sb32 == -1) r32 = 32'h0;
                 else r32 = sa32 % sb32;
        default: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b;
    case (op)
      OP_DIV:  if (sb == 0) r = '1;
               else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) r = sa;
               else r = sa / sb;
      OP_DIVU: if (b == 0) r = '1; else r = a / b;
      OP_REM:  if (sb == 0) r = sa;
               else if (sa == 64'sh8000_0000_0000_0000 && sb == -1) r = '0;
               else r = sa % sb;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    bit sp;
    if (w) sp = (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   sp = (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    return sp ? 1 : (w ? 33 : 65);
  endfunction

  // drives one request; returns #1 after the accept edge
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    @(negedge i_clk);
    while (!o_in_ready && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    i_in_valid = 1'b1; i_div_op = op; i_word_sel = w; i_src_a = a; i_src_b = b;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_src_a = '0; i_src_b = '0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input int hold);
    int edges;
    bit busy_ok;
    issue(op, w, a, b);
    edges = 1;
    busy_ok = o_busy;
    while (!o_out_valid && edges < 100) begin
      @(posedge i_clk); #1;
      edges++;
      busy_ok &= o_busy;
    end
    chk({tag, "_lat"}, 64'(edges), 64'(exp_lat));
    chk({tag, "_res"}, o_result, exp_res);
    chk({tag, "_busy"}, {63'b0, busy_ok}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      chk({tag, "_hold_res"}, o_result, exp_res);
      chk({tag, "_hold_vld"}, {63'b0, o_out_valid}, 64'd1);
    end
    @(negedge i_clk);
    i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_out_ready = 1'b0;
    chk({tag, "_drain_vld"}, {63'b0, o_out_valid}, 64'd0);
    chk({tag, "_drain_rdy"}, {63'b0, o_in_ready}, 64'd1);
  endtask

  initial begin
    logic [1:0]  op;
    logic        w;
    logic [63:0] a, b;

    i_rst_n = 1'b0; i_in_valid = 1'b0; i_src_a = '0; i_src_b = '0;
    i_div_op = '0; i_word_sel = 1'b0; i_flush = 1'b0; i_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {63'b0, o_in_ready}, 64'd1);
    chk("rst_busy", {63'b0, o_busy}, 64'd0);
    chk("rst_out_valid", {63'b0, o_out_valid}, 64'd0);
    chk("rst_result", o_result, 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
    run_op("remu_100_7", OP_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0);
    run_op("div_m7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("rem_m7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("divw_ovf", OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("remw_ovf", OP_REM, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("divu_by0", OP_DIVU, 1'b0, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("remu_by0", OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("divuw_by0", OP_DIVU, 1'b1, 64'd77, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("divuw_hold", OP_DIVU, 1'b1, 64'h1_0000_0009, 64'd3, 64'd3, 33, 10);

    // flush mid-iteration, then a back-to-back op
    issue(OP_DIVU, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge i_clk);
    @(negedge i_clk);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    chk("flush_calc_rdy", {63'b0, o_in_ready}, 64'd1);
    chk("flush_calc_busy", {63'b0, o_busy}, 64'd0);
    chk("flush_calc_vld", {63'b0, o_out_valid}, 64'd0);
    run_op("after_flush", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 65, 0);

    // flush in IDLE blocks acceptance
    @(negedge i_clk);
    i_in_valid = 1'b1; i_div_op = OP_DIVU; i_word_sel = 1'b0; i_src_a = 64'd50; i_src_b = 64'd5;
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_in_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_busy", {63'b0, o_busy}, 64'd0);

    // flush beats out_ready in DONE
    issue(OP_DIVU, 1'b0, 64'd8, 64'd0);
    chk("flushdone_pre_vld", {63'b0, o_out_valid}, 64'd1);
    @(negedge i_clk);
    i_flush = 1'b1; i_out_ready = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_out_ready = 1'b0;
    chk("flushdone_vld", {63'b0, o_out_valid}, 64'd0);
    chk("flushdone_busy", {63'b0, o_busy}, 64'd0);

    // async reset in the middle of CALC
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    repeat (5) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {63'b0, o_in_ready}, 64'd1);
    chk("arst_busy", {63'b0, o_busy}, 64'd0);
    chk("arst_out_valid", {63'b0, o_out_valid}, 64'd0);
    chk("arst_result", o_result, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0: b = 64'($urandom_range(0, 15));
        1: b = w ? {32'($urandom()), 32'h0} : 64'd0;
        2: begin
          a = w ? {32'($urandom()), 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {32'($urandom()), 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        3: b = {32'h0, 32'($urandom())} >> $urandom_range(0, 31);
        4: begin
          a = -64'($urandom_range(1, 1000));
          b = ($urandom_range(0, 1) != 0) ? -64'($urandom_range(1, 50)) : 64'($urandom_range(1, 50));
        end
        default: ;
      endcase
      run_op("rand", op, w, a, b, ref_res(op, w, a, b), ref_lat(op, w, a, b),
             int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
